// File: rtl/axis_requant.sv
// axis_requant: requantizes a signed fixed-point AXI-Stream sample from
// IW bits / IFW fractional bits to OW bits / OFW fractional bits using
// round-half-up and saturation. The output stage is a two-entry skid buffer
// whose input ready is registered.
// Optional saturation statistics: define AXIS_REQUANT_SAT_CNT_EN.
module axis_requant #(
    parameter int IW  = 19,
    parameter int IFW = 8,
    parameter int OW  = 8,
    parameter int OFW = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] axis_i_tdata,
    input  logic          axis_i_tvalid,
    output logic          axis_i_tready,
    output logic [OW-1:0] axis_o_tdata,
    output logic          axis_o_tvalid,
    input  logic          axis_o_tready,
    input  logic          sat_clr,
    output logic [15:0]   sat_cnt,
    output logic          sat_flag
);

    localparam int SHIFT = IFW - OFW;
    localparam int HSH   = (SHIFT > 0) ? SHIFT - 1 : 0;

    generate
        if (SHIFT < 0 || IW <= OW) begin : g_bad_cfg
            $error("axis_requant: need IFW >= OFW and IW > OW");
        end
    endgenerate

    // Rounding offset (half an output LSB) and saturation limits, all IW+1 bits
    localparam logic signed [IW:0] HALF = (SHIFT > 0) ? ((IW+1)'(1) << HSH) : '0;
    localparam logic signed [IW:0] MAXV = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] MINV = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};
    localparam logic [OW-1:0] MAXO = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] MINO = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t            state;
    logic              in_ready;
    logic              out_valid;
    logic [OW-1:0]     out_data;
    logic [OW-1:0]     skid;
    logic signed [IW:0] ext;
    logic signed [IW:0] shr;
    logic [OW-1:0]     q;
    logic              sat;
    logic              in_xfer;
    logic              out_xfer;

    assign axis_i_tready = in_ready;
    assign axis_o_tvalid = out_valid;
    assign axis_o_tdata  = out_data;
    assign in_xfer       = axis_i_tvalid & in_ready;
    assign out_xfer      = out_valid & axis_o_tready;

    // Round half up in IW+1 bits, then clip to the OW-bit signed range
    always_comb begin
        ext = {axis_i_tdata[IW-1], axis_i_tdata};
        shr = (ext + HALF) >>> SHIFT;
        sat = 1'b0;
        q   = shr[OW-1:0];
        if (shr > MAXV) begin
            q   = MAXO;
            sat = 1'b1;
        end else if (shr < MINV) begin
            q   = MINO;
            sat = 1'b1;
        end
    end

    // Skid FSM: output register plus one skid entry, all handshake outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (in_xfer) begin
                        out_data  <= q;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        out_data <= q;
                    end else if (in_xfer) begin
                        skid     <= q;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        out_data <= skid;
                        in_ready <= 1'b1;
                        state    <= BUSY;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_REQUANT_SAT_CNT_EN
    logic [15:0] cnt;
    logic        flag;

    assign sat_cnt  = cnt;
    assign sat_flag = flag;

    // Count accepted samples that were clipped; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else if (sat_clr) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else if (in_xfer && sat) begin
            if (cnt != '1) begin
                cnt <= cnt + 16'd1;
            end
            flag <= 1'b1;
        end
    end
`else
    logic unused_sat;

    assign sat_cnt    = '0;
    assign sat_flag   = 1'b0;
    assign unused_sat = sat_clr ^ sat;
`endif

endmodule

// File: tb/tb_axis_requant.sv
// tb_axis_requant: randomized self-checking bench for axis_requant with
// IW=16, IFW=8, OW=8, OFW=0. Expectations come from an integer model of
// round-half-up plus clamping; saturation counter expectations follow
// AXIS_REQUANT_SAT_CNT_EN.
module tb_axis_requant;

    localparam int N_RAND = 10000;

`ifdef AXIS_REQUANT_SAT_CNT_EN
    localparam bit SATEN = 1'b1;
`else
    localparam bit SATEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_cnt;
    logic        sat_flag;

    int total = 0;
    int bad   = 0;

    axis_requant #(.IW(16), .IFW(8), .OW(8), .OFW(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .axis_i_tdata  (i_data),
        .axis_i_tvalid (i_valid),
        .axis_i_tready (i_ready),
        .axis_o_tdata  (o_data),
        .axis_o_tvalid (o_valid),
        .axis_o_tready (o_ready),
        .sat_clr       (sat_clr),
        .sat_cnt       (sat_cnt),
        .sat_flag      (sat_flag)
    );

    always #5 clk = ~clk;

    // Value / 256 rounded half up, as a plain integer (floor of x/256 + 0.5)
    function automatic int model_round(input logic [15:0] x);
        int n;
        n = int'($signed(x)) + 128;
        if (n >= 0) return n / 256;
        return -((-n + 255) / 256);
    endfunction

    function automatic bit model_sat(input logic [15:0] x);
        int r;
        r = model_round(x);
        return (r > 127) || (r < -128);
    endfunction

    function automatic logic [7:0] model_out(input logic [15:0] x);
        int r;
        logic [31:0] t;
        r = model_round(x);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        t = 32'(r);
        return t[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b0; sat_clr = 1'b0; i_data = '0;
        repeat (3) tick();
        total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", i_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", o_valid); end
        total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_tdata got=%h want=00", o_data); end
        total++; if (sat_cnt !== 16'h0) begin bad++; $display("FAIL reset_satcnt got=%h want=0", sat_cnt); end
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_satflag got=%b want=0", sat_flag); end
        rst_n = 1'b1;
        tick();
        total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_release_tready got=%b want=1", i_ready); end
    endtask

    task automatic test_rounding();
        logic [15:0] vin [3];
        logic [7:0]  vexp [3];
        vin[0] = 16'h0180; vexp[0] = 8'h02;
        vin[1] = 16'h00FF; vexp[1] = 8'h01;
        vin[2] = 16'hFE80; vexp[2] = 8'hFF;
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_data = vin[i];
            tick();
            i_valid = 1'b0;
            total++;
            if (o_valid !== 1'b1 || o_data !== vexp[i]) begin
                bad++; $display("FAIL round_%0d in=%h got=%b/%h want=1/%h", i, vin[i], o_valid, o_data, vexp[i]);
            end
            tick();
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL round_drain_%0d got=%b want=0", i, o_valid); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] vin [2];
        logic [7:0]  vexp [2];
        vin[0] = 16'h7FFF; vexp[0] = 8'h7F;
        vin[1] = 16'h8000; vexp[1] = 8'h80;
        o_ready = 1'b1;
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        total++; if (sat_cnt !== 16'h0) begin bad++; $display("FAIL sat_preclear got=%h want=0", sat_cnt); end
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1; i_data = vin[i];
            tick();
            i_valid = 1'b0;
            total++;
            if (o_valid !== 1'b1 || o_data !== vexp[i]) begin
                bad++; $display("FAIL sat_data_%0d in=%h got=%b/%h want=1/%h", i, vin[i], o_valid, o_data, vexp[i]);
            end
            tick();
        end
        total++; if (sat_cnt !== (SATEN ? 16'd1 : 16'd0)) begin bad++; $display("FAIL sat_cnt got=%0d want=%0d", sat_cnt, SATEN ? 1 : 0); end
        total++; if (sat_flag !== SATEN) begin bad++; $display("FAIL sat_flag got=%b want=%b", sat_flag, SATEN); end
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        total++; if (sat_cnt !== 16'h0 || sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clear got=%h/%b want=0/0", sat_cnt, sat_flag); end
        // clear held on the same edge as a saturated accept
        sat_clr = 1'b1; i_valid = 1'b1; i_data = 16'h7FFF;
        tick();
        sat_clr = 1'b0; i_valid = 1'b0;
        total++; if (sat_cnt !== 16'h0 || sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clr_priority got=%h/%b want=0/0", sat_cnt, sat_flag); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] s [5];
        int idx = 0;
        int oidx = 0;
        int last = -1;
        int gaps = 0;
        for (int i = 0; i < 5; i++) s[i] = 16'($urandom);
        o_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            i_valid = (idx < 5);
            if (idx < 5) i_data = s[idx];
            if (i_valid && i_ready) idx++;
            tick();
        end
        total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", idx); end
        total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL bp_tready got=%b want=0", i_ready); end
        total++;
        if (o_valid !== 1'b1 || o_data !== model_out(s[0])) begin
            bad++; $display("FAIL bp_hold got=%b/%h want=1/%h", o_valid, o_data, model_out(s[0]));
        end
        o_ready = 1'b1;
        for (int c = 0; c < 30 && oidx < 5; c++) begin
            i_valid = (idx < 5);
            if (idx < 5) i_data = s[idx];
            if (o_valid && o_ready) begin
                total++;
                if (o_data !== model_out(s[oidx])) begin
                    bad++; $display("FAIL bp_out_%0d got=%h want=%h", oidx, o_data, model_out(s[oidx]));
                end
                if (last >= 0 && c != last + 1) gaps++;
                last = c;
                oidx++;
            end
            if (i_valid && i_ready) idx++;
            tick();
        end
        i_valid = 1'b0;
        total++; if (oidx !== 5) begin bad++; $display("FAIL bp_count got=%0d want=5", oidx); end
        total++; if (gaps !== 0) begin bad++; $display("FAIL bp_gaps got=%0d want=0", gaps); end
    endtask

    task automatic test_throughput();
        logic [15:0] s [100];
        int idx = 0;
        int oidx = 0;
        int first_acc = -1;
        int first_out = -1;
        int last_out = -1;
        for (int i = 0; i < 100; i++) s[i] = 16'($urandom);
        o_ready = 1'b1;
        for (int c = 0; c < 300 && oidx < 100; c++) begin
            i_valid = (idx < 100);
            if (idx < 100) i_data = s[idx];
            if (o_valid && o_ready) begin
                total++;
                if (o_data !== model_out(s[oidx])) begin
                    bad++; $display("FAIL tp_out_%0d got=%h want=%h", oidx, o_data, model_out(s[oidx]));
                end
                if (first_out < 0) first_out = c;
                last_out = c;
                oidx++;
            end
            if (i_valid && i_ready) begin
                if (first_acc < 0) first_acc = c;
                idx++;
            end
            tick();
        end
        i_valid = 1'b0;
        total++; if (oidx !== 100) begin bad++; $display("FAIL tp_count got=%0d want=100", oidx); end
        total++; if (first_out !== first_acc + 1) begin bad++; $display("FAIL tp_latency got=%0d want=%0d", first_out, first_acc + 1); end
        total++; if (last_out - first_out !== 99) begin bad++; $display("FAIL tp_span got=%0d want=99", last_out - first_out); end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        int c = 0;
        o_ready = 1'b0;
        i_valid = 1'b1;
        while (i_ready && c < 10) begin
            i_data = 16'($urandom);
            tick();
            c++;
        end
        total++; if (i_ready !== 1'b0 || o_valid !== 1'b1) begin bad++; $display("FAIL rm_full got=%b/%b want=0/1", i_ready, o_valid); end
        rst_n = 1'b0;
        tick();
        total++;
        if (o_valid !== 1'b0 || i_ready !== 1'b0 || o_data !== 8'h00) begin
            bad++; $display("FAIL rm_reset got=%b/%b/%h want=0/0/00", o_valid, i_ready, o_data);
        end
        rst_n = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (o_valid) stale++;
            tick();
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL rm_stale got=%0d want=0", stale); end
        i_valid = 1'b1; i_data = 16'h0300;
        tick();
        i_valid = 1'b0;
        total++; if (o_valid !== 1'b1 || o_data !== 8'h03) begin bad++; $display("FAIL rm_fresh got=%b/%h want=1/03", o_valid, o_data); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [7:0] want;
        logic [7:0] prev_data = '0;
        bit         prev_stall = 1'b0;
        int sent = 0;
        int outs = 0;
        int satn = 0;
        int unstable = 0;
        bit acc;
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        i_valid = 1'b0;
        for (int c = 0; c < 60000 && outs < N_RAND; c++) begin
            if (!i_valid && sent < N_RAND && $urandom_range(0, 99) < 60) begin
                i_valid = 1'b1;
                i_data  = 16'($urandom);
            end
            o_ready = ($urandom_range(0, 99) < 60);
            if (prev_stall && (o_valid !== 1'b1 || o_data !== prev_data)) unstable++;
            acc = i_valid && i_ready;
            if (acc) begin
                exp_q.push_back(model_out(i_data));
                if (model_sat(i_data)) satn++;
                sent++;
            end
            if (o_valid && o_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_extra got=%h want=none", o_data);
                end else begin
                    want = exp_q.pop_front();
                    if (o_data !== want) begin
                        bad++; $display("FAIL rand_out_%0d got=%h want=%h", outs, o_data, want);
                    end
                end
                outs++;
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
            tick();
            if (acc) i_valid = 1'b0;
        end
        i_valid = 1'b0; o_ready = 1'b0;
        total++; if (outs !== N_RAND) begin bad++; $display("FAIL rand_count got=%0d want=%0d", outs, N_RAND); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", exp_q.size()); end
        total++; if (unstable !== 0) begin bad++; $display("FAIL rand_stall_stable got=%0d want=0", unstable); end
        total++;
        if (sat_cnt !== (SATEN ? 16'((satn > 65535) ? 65535 : satn) : 16'd0)) begin
            bad++; $display("FAIL rand_satcnt got=%0d want=%0d", sat_cnt, SATEN ? satn : 0);
        end
        total++; if (sat_flag !== (SATEN && satn > 0)) begin bad++; $display("FAIL rand_satflag got=%b want=%b", sat_flag, SATEN && satn > 0); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
